// File: rtl/ai_paddle_controller.sv
// AI paddle controller: follows the collision predictor's impact line after a
// reaction delay counted in frames, and drifts back to centre when idle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// CENTER   | no usable prediction (or disabled); paddle homes to centre
// REACT    | prediction latched, counting vsyncs before tracking starts
// TRACK    | stepping toward the latched target once per frame
module ai_paddle_controller #(
   parameter int SCREEN_H        = 480,
   parameter int PADDLE_H        = 64,
   parameter int STEP            = 4,
   parameter int DEAD_ZONE       = 2,
   parameter int REACTION_FRAMES = 3
) (
   input  logic       clock_in,
   input  logic       reset_in,
   input  logic       vsync_start_in,
   input  logic       enable_in,
   input  logic       predicted_valid_in,
   input  logic [9:0] predicted_y_in,
   output logic [9:0] paddle_y_out,
   output logic       paddle_move_up_out,
   output logic       paddle_move_down_out,
   output logic       tracking_out
);

   localparam int CENTRE_I = (SCREEN_H - PADDLE_H) / 2;
   localparam int MAX_I    = SCREEN_H - PADDLE_H;

   localparam logic [9:0]        CENTRE  = 10'(CENTRE_I);
   localparam logic [9:0]        MAX_Y   = 10'(MAX_I);
   localparam logic [9:0]        STEP_U  = 10'(STEP);
   localparam logic signed [10:0] HALF_S = 11'(PADDLE_H / 2);
   localparam logic signed [10:0] MAX_S  = 11'(MAX_I);
   localparam logic signed [10:0] STEP_S = 11'(STEP);
   localparam logic signed [10:0] DZ_S   = 11'(DEAD_ZONE);
   localparam logic [7:0]        RF      = 8'(REACTION_FRAMES);

   typedef enum logic [1:0] {
      ST_CENTER = 2'd0,
      ST_REACT  = 2'd1,
      ST_TRACK  = 2'd2
   } state_t;

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [9:0]  r_tgt;
   logic        r_valid_d;
   logic [9:0]  r_y;
   logic        r_up;
   logic        r_dn;
   logic        r_tracking;

   logic               w_rise;
   logic               w_drop;
   logic signed [10:0] w_t_raw;
   logic [9:0]         w_t_clamped;
   logic [9:0]         w_goal;
   logic signed [10:0] w_d;
   logic signed [10:0] w_abs;
   logic [9:0]         w_mag;
   logic               w_move_ok;
   logic [9:0]         w_next_y;
   logic [7:0]         w_cnt_inc;

   assign w_rise    = predicted_valid_in & ~r_valid_d;
   assign w_drop    = (r_state != ST_CENTER) & ~predicted_valid_in;
   assign w_cnt_inc = r_cnt + 8'd1;

   // Impact line converted to a paddle-top target, clamped onto the screen.
   always_comb begin
      w_t_raw     = $signed({1'b0, predicted_y_in}) - HALF_S;
      w_t_clamped = w_t_raw[9:0];
      if (w_t_raw < 11'sd0)
         w_t_clamped = 10'd0;
      else if (w_t_raw > MAX_S)
         w_t_clamped = MAX_Y;
   end

   // Goal for this frame; a valid drop homes to centre in the same cycle.
   always_comb begin
      w_goal = CENTRE;
      if (!w_drop) begin
         if (r_state == ST_TRACK)
            w_goal = r_tgt;
         else if (r_state == ST_REACT)
            w_goal = r_y;
      end
   end

   // One bounded step toward the goal; never overshoots so never leaves range.
   always_comb begin
      w_d       = $signed({1'b0, w_goal}) - $signed({1'b0, r_y});
      w_abs     = (w_d < 11'sd0) ? -w_d : w_d;
      w_move_ok = (w_abs > DZ_S);
      w_mag     = (w_abs > STEP_S) ? STEP_U : w_abs[9:0];
      w_next_y  = r_y;
      if (w_move_ok) begin
         if (w_d < 11'sd0)
            w_next_y = r_y - w_mag;
         else
            w_next_y = r_y + w_mag;
      end
   end

   // Controller FSM with registered paddle position, move flags and tracking.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         r_state    <= ST_CENTER;
         r_cnt      <= 8'd0;
         r_tgt      <= CENTRE;
         r_valid_d  <= 1'b0;
         r_y        <= CENTRE;
         r_up       <= 1'b0;
         r_dn       <= 1'b0;
         r_tracking <= 1'b0;
      end else begin
         r_valid_d <= predicted_valid_in;
         if (!enable_in) begin
            r_state    <= ST_CENTER;
            r_tracking <= 1'b0;
            if (vsync_start_in) begin
               r_up <= 1'b0;
               r_dn <= 1'b0;
            end
         end else if (w_rise) begin
            // A fresh prediction always restarts the reaction delay; the
            // coincident vsync is swallowed.
            r_tgt <= w_t_clamped;
            r_cnt <= 8'd0;
            if (RF == 8'd0) begin
               r_state    <= ST_TRACK;
               r_tracking <= 1'b1;
            end else begin
               r_state    <= ST_REACT;
               r_tracking <= 1'b0;
            end
            if (vsync_start_in) begin
               r_up <= 1'b0;
               r_dn <= 1'b0;
            end
         end else if (w_drop) begin
            r_state    <= ST_CENTER;
            r_tracking <= 1'b0;
            if (vsync_start_in) begin
               r_y  <= w_next_y;
               r_up <= w_move_ok & (w_d < 11'sd0);
               r_dn <= w_move_ok & (w_d > 11'sd0);
            end
         end else begin
            case (r_state)
               ST_CENTER, ST_TRACK: begin
                  if (vsync_start_in) begin
                     r_y  <= w_next_y;
                     r_up <= w_move_ok & (w_d < 11'sd0);
                     r_dn <= w_move_ok & (w_d > 11'sd0);
                  end
               end
               ST_REACT: begin
                  if (vsync_start_in) begin
                     r_cnt <= w_cnt_inc;
                     r_up  <= 1'b0;
                     r_dn  <= 1'b0;
                     if (w_cnt_inc == RF) begin
                        r_state    <= ST_TRACK;
                        r_tracking <= 1'b1;
                     end
                  end
               end
               default: begin
                  r_state    <= ST_CENTER;
                  r_tracking <= 1'b0;
               end
            endcase
         end
      end
   end

   assign paddle_y_out         = r_y;
   assign paddle_move_up_out   = r_up;
   assign paddle_move_down_out = r_dn;
   assign tracking_out         = r_tracking;

endmodule

// File: tb/tb_ai_paddle_controller.sv
// Bench for ai_paddle_controller: directed scenarios followed by random
// traffic, all compared against a frame-level behavioural model.
module tb_ai_paddle_controller;

   localparam int CENTRE = 208;
   localparam int MAXY   = 416;
   localparam int HALF   = 32;
   localparam int STEPV  = 4;
   localparam int DZ     = 2;
   localparam int RFR    = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       vs  = 1'b0;
   logic       en  = 1'b1;
   logic       pv  = 1'b0;
   logic [9:0] py  = 10'd0;
   logic [9:0] y;
   logic       up;
   logic       dn;
   logic       trk;

   int checks   = 0;
   int failures = 0;

   // model: frames_left < 0 homing, > 0 still reacting, == 0 tracking
   int m_y       = CENTRE;
   int m_tgt     = CENTRE;
   int m_left    = -1;
   bit m_up      = 1'b0;
   bit m_dn      = 1'b0;
   bit m_vprev   = 1'b0;

   ai_paddle_controller dut (
      .clock_in             (clk),
      .reset_in             (rst),
      .vsync_start_in       (vs),
      .enable_in            (en),
      .predicted_valid_in   (pv),
      .predicted_y_in       (py),
      .paddle_y_out         (y),
      .paddle_move_up_out   (up),
      .paddle_move_down_out (dn),
      .tracking_out         (trk)
   );

   always #5 clk = ~clk;

   task automatic move_toward(input int goal);
      int d;
      int m;
      d = goal - m_y;
      m_up = 1'b0;
      m_dn = 1'b0;
      if (d > DZ || d < -DZ) begin
         m = (d < 0) ? -d : d;
         if (m > STEPV) m = STEPV;
         if (d < 0) begin
            m_y  = m_y - m;
            m_up = 1'b1;
         end else begin
            m_y  = m_y + m;
            m_dn = 1'b1;
         end
      end
   endtask

   task automatic model_step();
      bit rise;
      int t;
      if (rst) begin
         m_y = CENTRE; m_tgt = CENTRE; m_left = -1;
         m_up = 1'b0; m_dn = 1'b0; m_vprev = 1'b0;
      end else begin
         rise    = pv && !m_vprev;
         m_vprev = pv;
         if (!en) begin
            m_left = -1;
            if (vs) begin m_up = 1'b0; m_dn = 1'b0; end
         end else if (rise) begin
            t = int'(py) - HALF;
            if (t < 0) t = 0;
            if (t > MAXY) t = MAXY;
            m_tgt  = t;
            m_left = RFR;
            if (vs) begin m_up = 1'b0; m_dn = 1'b0; end
         end else if (m_left >= 0 && !pv) begin
            m_left = -1;
            if (vs) move_toward(CENTRE);
         end else if (m_left < 0) begin
            if (vs) move_toward(CENTRE);
         end else if (m_left > 0) begin
            if (vs) begin
               m_left = m_left - 1;
               m_up = 1'b0; m_dn = 1'b0;
            end
         end else begin
            if (vs) move_toward(m_tgt);
         end
      end
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
      end
   endtask

   // Apply current inputs for one clock, update the model, compare outputs.
   task automatic tick(input bit v);
      vs = v;
      @(posedge clk);
      model_step();
      #1;
      chk("paddle_y", int'(y), m_y);
      chk("move_up", int'(up), int'(m_up));
      chk("move_dn", int'(dn), int'(m_dn));
      chk("tracking", int'(trk), (m_left == 0) ? 1 : 0);
      @(negedge clk);
      vs = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         tick(1'b0);
         tick(1'b1);
      end
   endtask

   initial begin
      @(negedge clk);
      rst = 1'b1;
      tick(1'b0);
      tick(1'b1);
      rst = 1'b0;
      chk("reset_y", int'(y), CENTRE);
      chk("reset_trk", int'(trk), 0);

      // idle frames stay centred
      for (int i = 0; i < 5; i++) begin
         frames(1);
         chk("idle_y", int'(y), CENTRE);
         chk("idle_flags", int'(up) + int'(dn), 0);
      end

      // prediction at 400, later raw changes ignored
      pv = 1'b1; py = 10'd400;
      tick(1'b0);
      py = 10'd5;
      for (int i = 1; i <= 3; i++) begin
         frames(1);
         chk("react_y", int'(y), CENTRE);
         chk("react_trk", int'(trk), (i == 3) ? 1 : 0);
      end
      for (int k = 1; k <= 40; k++) begin
         frames(1);
         chk("track_y", int'(y), CENTRE + 4 * k);
         chk("track_dn", int'(dn), 1);
      end
      chk("track_end", int'(y), 368);
      frames(2);
      chk("hold_y", int'(y), 368);
      chk("hold_flags", int'(up) + int'(dn), 0);

      // home, then drop valid mid-track at 300 on a vsync
      pv = 1'b0;
      tick(1'b0);
      frames(40);
      chk("home1", int'(y), CENTRE);
      pv = 1'b1; py = 10'd400;
      tick(1'b0);
      frames(3 + 23);
      chk("at300", int'(y), 300);
      pv = 1'b0;
      tick(1'b1);
      chk("drop_y", int'(y), 296);
      chk("drop_up", int'(up), 1);
      chk("drop_trk", int'(trk), 0);
      frames(22);
      chk("home2", int'(y), CENTRE);

      // low clamp
      pv = 1'b1; py = 10'd10;
      tick(1'b0);
      frames(3 + 52);
      chk("clamp_lo", int'(y), 0);
      frames(2);
      chk("clamp_lo_hold", int'(y), 0);
      chk("clamp_lo_flags", int'(up) + int'(dn), 0);
      pv = 1'b0;
      tick(1'b0);
      frames(52);
      chk("home3", int'(y), CENTRE);

      // high clamp
      pv = 1'b1; py = 10'd470;
      tick(1'b0);
      frames(3 + 52);
      chk("clamp_hi", int'(y), MAXY);
      frames(1);
      chk("clamp_hi_hold", int'(y), MAXY);
      pv = 1'b0;
      tick(1'b0);
      frames(52);
      chk("home4", int'(y), CENTRE);

      // dead zone: target 210 no move, target 211 one short step
      pv = 1'b1; py = 10'd242;
      tick(1'b0);
      frames(4);
      chk("dz_y", int'(y), CENTRE);
      chk("dz_flags", int'(up) + int'(dn), 0);
      chk("dz_trk", int'(trk), 1);
      pv = 1'b0;
      tick(1'b0);
      pv = 1'b1; py = 10'd243;
      tick(1'b0);
      frames(4);
      chk("short_y", int'(y), 211);
      chk("short_dn", int'(dn), 1);

      // reset mid-track at 340
      pv = 1'b0;
      tick(1'b0);
      frames(1);
      chk("home5", int'(y), CENTRE);
      pv = 1'b1; py = 10'd400;
      tick(1'b0);
      frames(3 + 33);
      chk("at340", int'(y), 340);
      rst = 1'b1; pv = 1'b0;
      tick(1'b0);
      rst = 1'b0;
      chk("rst_mid_y", int'(y), CENTRE);
      chk("rst_mid_trk", int'(trk), 0);

      // disable during track freezes the paddle
      pv = 1'b1; py = 10'd400;
      tick(1'b0);
      frames(3 + 5);
      chk("pre_dis", int'(y), 228);
      en = 1'b0;
      frames(4);
      chk("dis_y", int'(y), 228);
      chk("dis_trk", int'(trk), 0);
      en = 1'b1;
      frames(5);
      chk("reen_home", int'(y), CENTRE);

      // rise coinciding with vsync: latched, not counted, no move
      pv = 1'b0;
      tick(1'b0);
      pv = 1'b1; py = 10'd400;
      tick(1'b1);
      chk("rise_vs_y", int'(y), CENTRE);
      chk("rise_vs_trk", int'(trk), 0);
      frames(2);
      chk("rise_vs_cnt", int'(trk), 0);
      frames(1);
      chk("rise_vs_trk3", int'(trk), 1);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) pv = ~pv;
         if ($urandom_range(0, 3) == 0) py = 10'($urandom_range(0, 1023));
         en  = ($urandom_range(0, 49) != 0);
         rst = ($urandom_range(0, 499) == 0);
         tick($urandom_range(0, 3) == 0);
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
